mem_refill_ctrl: RTL and testbench

Cache-side initiator for the line-granular main-memory interface. It takes one cache-miss request at a time, optionally writes back a dirty victim line, then fetches the refill line. It returns that line to the cache as a single-cycle response. It sits between the cache controller and the RAM, drives the RAM's address, write-data and write-enable inputs, and models a fixed access latency with a counter.

---
 rtl/mem_refill_ctrl.sv | 108 ++++++++++
 tb/tb_mem_refill_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_refill_ctrl.sv
// mem_refill_ctrl: services one cache miss at a time against a fixed-latency,
// line-granular RAM. An optional write-back of the dirty victim runs first,
// then the refill read, then a one-cycle response to the cache.
module mem_refill_ctrl #(
   parameter int ADDR_W      = 26,
   parameter int LINE_W      = 128,
   parameter int MEM_LATENCY = 3     // 1..255 cycles per RAM access
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_line_addr,
   input  logic              req_wb,
   input  logic [ADDR_W-1:0] req_wb_addr,
   input  logic [LINE_W-1:0] req_wb_data,
   output logic              resp_valid,
   output logic [LINE_W-1:0] resp_data,
   output logic [ADDR_W-1:0] resp_line_addr,
   output logic [ADDR_W-1:0] data_requested,
   output logic [ADDR_W-1:0] where_to_write,
   output logic [LINE_W-1:0] data_to_write,
   output logic              write_to_mem,
   input  logic [LINE_W-1:0] data_returned,
   output logic [15:0]       fill_count,
   output logic [15:0]       wb_count
);

   typedef enum logic [1:0] {IDLE, WB, FILL, RESP} state_t;

   // Counter counts down to zero, so an access of L cycles starts at L-1.
   localparam logic [7:0] LAT_M1 = 8'(MEM_LATENCY - 1);

   state_t     state;
   logic [7:0] cnt;

   // The RAM-facing address/data outputs double as the registered request
   // fields, so the captured request lives only in the output registers.
   // Write enable and response valid are single-cycle pulses: default low.
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         cnt            <= '0;
         req_ready      <= 1'b1;
         resp_valid     <= 1'b0;
         write_to_mem   <= 1'b0;
         resp_data      <= '0;
         resp_line_addr <= '0;
         data_requested <= '0;
         where_to_write <= '0;
         data_to_write  <= '0;
         fill_count     <= '0;
         wb_count       <= '0;
      end else begin
         write_to_mem <= 1'b0;
         resp_valid   <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  req_ready      <= 1'b0;
                  data_requested <= req_line_addr;
                  where_to_write <= req_wb_addr;
                  data_to_write  <= req_wb_data;
                  cnt            <= LAT_M1;
                  if (req_wb) begin
                     write_to_mem <= 1'b1;   // only the first WB cycle writes
                     state        <= WB;
                  end else begin
                     state <= FILL;
                  end
               end
            end
            WB: begin
               if (cnt != 8'd0) begin
                  cnt <= cnt - 8'd1;
               end else begin
                  wb_count <= wb_count + 16'd1;
                  cnt      <= LAT_M1;
                  state    <= FILL;
               end
            end
            FILL: begin
               // RAM data is only meaningful once the access latency elapsed.
               if (cnt != 8'd0) begin
                  cnt <= cnt - 8'd1;
               end else begin
                  resp_data      <= data_returned;
                  resp_line_addr <= data_requested;
                  fill_count     <= fill_count + 16'd1;
                  resp_valid     <= 1'b1;
                  state          <= RESP;
               end
            end
            RESP: begin
               // Ready reasserts only after the response cycle, so no request
               // can be taken while resp_valid is high.
               req_ready <= 1'b1;
               state     <= IDLE;
            end
            default: begin
               req_ready <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_refill_ctrl.sv
// Directed bench for mem_refill_ctrl: a behavioural line RAM, a per-cycle
// vector table for back-to-back clean/dirty misses, and hand sequences for
// same-line write-back, queued requests, mid-operation reset and latency 1.
module tb_mem_refill_ctrl;

   localparam int AW = 26;
   localparam int LW = 128;

   localparam logic [LW-1:0] C_LINE = 128'h0000000F_0000000E_0000000D_0000000C;
   localparam logic [LW-1:0] DEAD   = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
   localparam logic [LW-1:0] A5     = {16{8'hA5}};
   localparam logic [LW-1:0] M3     = {4{32'h3}};

   logic          clk = 1'b0;
   logic          reset;
   logic          req_valid;
   logic [AW-1:0] req_line_addr;
   logic          req_wb;
   logic [AW-1:0] req_wb_addr;
   logic [LW-1:0] req_wb_data;

   logic          req_ready, resp_valid, write_to_mem;
   logic [LW-1:0] resp_data, data_to_write, data_returned;
   logic [AW-1:0] resp_line_addr, data_requested, where_to_write;
   logic [15:0]   fill_count, wb_count;

   logic          req_ready1, resp_valid1, write_to_mem1;
   logic [LW-1:0] resp_data1, data_to_write1, data_returned1;
   logic [AW-1:0] resp_line_addr1, data_requested1, where_to_write1;
   logic [15:0]   fill_count1, wb_count1;

   logic [LW-1:0] mem [64];

   int pass_n = 0;
   int total_n = 0;

   always #5 clk = ~clk;

   mem_refill_ctrl #(.ADDR_W(AW), .LINE_W(LW), .MEM_LATENCY(3)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_line_addr(req_line_addr), .req_wb(req_wb), .req_wb_addr(req_wb_addr),
      .req_wb_data(req_wb_data), .resp_valid(resp_valid), .resp_data(resp_data),
      .resp_line_addr(resp_line_addr), .data_requested(data_requested),
      .where_to_write(where_to_write), .data_to_write(data_to_write),
      .write_to_mem(write_to_mem), .data_returned(data_returned),
      .fill_count(fill_count), .wb_count(wb_count));

   // Second instance at the minimum latency; reads the same RAM, never writes it.
   mem_refill_ctrl #(.ADDR_W(AW), .LINE_W(LW), .MEM_LATENCY(1)) dut1 (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready1),
      .req_line_addr(req_line_addr), .req_wb(req_wb), .req_wb_addr(req_wb_addr),
      .req_wb_data(req_wb_data), .resp_valid(resp_valid1), .resp_data(resp_data1),
      .resp_line_addr(resp_line_addr1), .data_requested(data_requested1),
      .where_to_write(where_to_write1), .data_to_write(data_to_write1),
      .write_to_mem(write_to_mem1), .data_returned(data_returned1),
      .fill_count(fill_count1), .wb_count(wb_count1));

   // Behavioural RAM: combinational read, write on the clock edge.
   assign data_returned  = mem[data_requested[5:0]];
   assign data_returned1 = mem[data_requested1[5:0]];
   always @(posedge clk) if (write_to_mem) mem[where_to_write[5:0]] <= data_to_write;

   typedef struct {
      logic          rv;  logic [AW-1:0] la;  logic wb;
      logic [AW-1:0] wba; logic [LW-1:0] wbd;
      logic          rdy; logic rsv; logic wr;
      logic [15:0]   fc;  logic [15:0] wc;
      logic [AW-1:0] dreq; logic [AW-1:0] wwa;
      logic [LW-1:0] rd;  logic [AW-1:0] ra;
   } vec_t;

   vec_t vec [14];

   function automatic vec_t mk(logic rv, logic [AW-1:0] la, logic wb,
                               logic [AW-1:0] wba, logic [LW-1:0] wbd,
                               logic rdy, logic rsv, logic wr,
                               logic [15:0] fc, logic [15:0] wc,
                               logic [AW-1:0] dreq, logic [AW-1:0] wwa,
                               logic [LW-1:0] rd, logic [AW-1:0] ra);
      vec_t v;
      v.rv = rv; v.la = la; v.wb = wb; v.wba = wba; v.wbd = wbd;
      v.rdy = rdy; v.rsv = rsv; v.wr = wr; v.fc = fc; v.wc = wc;
      v.dreq = dreq; v.wwa = wwa; v.rd = rd; v.ra = ra;
      return v;
   endfunction

   task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      total_n++;
      if (act === exp) pass_n++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req_valid = 1'b0; req_line_addr = '0; req_wb = 1'b0;
      req_wb_addr = '0; req_wb_data = '0;
   endtask

   initial begin
      int n, acc, resp_n, bad_rdy, r0, r1, wr1_n;
      int acc_cyc [2];
      int resp_cyc [4];
      logic [AW-1:0] resp_a [4];
      logic [LW-1:0] resp_d [4];

      for (int i = 0; i < 64; i++) mem[i] = {4{32'(i)}};
      mem[1] = C_LINE;

      //          rv la     wb wba wbd   rdy rsv wr fc wc dreq wwa rd      ra
      vec[0]  = mk(1, 1,     0, 0, '0,   1, 0, 0, 0, 0, 0, 0, '0,     0);
      vec[1]  = mk(0, 0,     0, 0, '0,   0, 0, 0, 0, 0, 1, 0, '0,     0);
      vec[2]  = mk(1, 'h3f,  0, 0, '0,   0, 0, 0, 0, 0, 1, 0, '0,     0);
      vec[3]  = mk(0, 0,     0, 0, '0,   0, 0, 0, 0, 0, 1, 0, '0,     0);
      vec[4]  = mk(1, 7,     0, 0, '0,   0, 1, 0, 1, 0, 1, 0, C_LINE, 1);
      vec[5]  = mk(1, 3,     1, 2, DEAD, 1, 0, 0, 1, 0, 1, 0, C_LINE, 1);
      vec[6]  = mk(0, 0,     0, 0, '0,   0, 0, 1, 1, 0, 3, 2, C_LINE, 1);
      vec[7]  = mk(0, 0,     0, 0, '0,   0, 0, 0, 1, 0, 3, 2, C_LINE, 1);
      vec[8]  = mk(0, 0,     0, 0, '0,   0, 0, 0, 1, 0, 3, 2, C_LINE, 1);
      vec[9]  = mk(0, 0,     0, 0, '0,   0, 0, 0, 1, 1, 3, 2, C_LINE, 1);
      vec[10] = mk(0, 0,     0, 0, '0,   0, 0, 0, 1, 1, 3, 2, C_LINE, 1);
      vec[11] = mk(0, 0,     0, 0, '0,   0, 0, 0, 1, 1, 3, 2, C_LINE, 1);
      vec[12] = mk(0, 0,     0, 0, '0,   0, 1, 0, 2, 1, 3, 2, M3,     3);
      vec[13] = mk(0, 0,     0, 0, '0,   1, 0, 0, 2, 1, 3, 2, M3,     3);

      // Reset held two cycles.
      idle_inputs();
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      chk("rst_ready", LW'(req_ready), 1);
      chk("rst_outs", LW'({resp_valid, write_to_mem, fill_count, wb_count}), 0);
      chk("rst_addrs", LW'({data_requested, where_to_write, resp_line_addr}), 0);
      chk("rst_data", resp_data | data_to_write, 0);

      // Clean miss (addr 1), a dirty miss (wb 2, fill 3) right behind it.
      for (int i = 0; i < 14; i++) begin
         req_valid = vec[i].rv; req_line_addr = vec[i].la; req_wb = vec[i].wb;
         req_wb_addr = vec[i].wba; req_wb_data = vec[i].wbd;
         chk($sformatf("v%0d_ready", i), LW'(req_ready), LW'(vec[i].rdy));
         chk($sformatf("v%0d_resp_valid", i), LW'(resp_valid), LW'(vec[i].rsv));
         chk($sformatf("v%0d_write_to_mem", i), LW'(write_to_mem), LW'(vec[i].wr));
         chk($sformatf("v%0d_counts", i), LW'({fill_count, wb_count}), LW'({vec[i].fc, vec[i].wc}));
         chk($sformatf("v%0d_data_requested", i), LW'(data_requested), LW'(vec[i].dreq));
         chk($sformatf("v%0d_where_to_write", i), LW'(where_to_write), LW'(vec[i].wwa));
         chk($sformatf("v%0d_resp_data", i), resp_data, vec[i].rd);
         chk($sformatf("v%0d_resp_addr", i), LW'(resp_line_addr), LW'(vec[i].ra));
         tick();
      end
      idle_inputs();
      chk("wb_ram_contents", mem[2], DEAD);

      // Same-line write-back then fill: fill must see the written data.
      req_valid = 1'b1; req_line_addr = 5; req_wb = 1'b1;
      req_wb_addr = 5; req_wb_data = A5;
      tick();
      idle_inputs();
      n = 1;
      while (resp_valid !== 1'b1 && n < 20) begin tick(); n++; end
      chk("same_line_latency", LW'(n), 7);
      chk("same_line_data", resp_data, A5);
      chk("same_line_addr", LW'(resp_line_addr), 5);
      chk("same_line_counts", LW'({fill_count, wb_count}), LW'({16'd3, 16'd2}));
      tick();

      // req_valid held high across two queued clean requests.
      acc = 0; resp_n = 0; bad_rdy = 0;
      acc_cyc[0] = -1; acc_cyc[1] = -1;
      for (int c = 0; c < 12; c++) begin
         req_valid = (acc < 2);
         req_line_addr = (acc == 0) ? AW'(6'h10) : AW'(6'h11);
         if (resp_valid && resp_n < 4) begin
            resp_cyc[resp_n] = c; resp_a[resp_n] = resp_line_addr;
            resp_d[resp_n] = resp_data; resp_n++;
         end
         if (c >= 1 && c <= 4 && req_ready) bad_rdy++;
         if (req_valid && req_ready && acc < 2) begin acc_cyc[acc] = c; acc++; end
         tick();
      end
      idle_inputs();
      chk("queue_ready_low", LW'(bad_rdy), 0);
      chk("queue_second_accept", LW'(acc_cyc[1]), 5);
      chk("queue_resp_count", LW'(resp_n), 2);
      if (resp_n == 2) begin
         chk("queue_resp0_cycle", LW'(resp_cyc[0]), 4);
         chk("queue_resp1_cycle", LW'(resp_cyc[1]), 9);
         chk("queue_resp0_addr", LW'(resp_a[0]), 'h10);
         chk("queue_resp1_addr", LW'(resp_a[1]), 'h11);
         chk("queue_resp1_data", resp_d[1], {4{32'h11}});
      end
      chk("queue_fill_count", LW'(fill_count), 5);

      // Reset during the FILL phase of a dirty miss.
      req_valid = 1'b1; req_line_addr = 'h21; req_wb = 1'b1;
      req_wb_addr = 'h20; req_wb_data = DEAD;
      tick();
      idle_inputs();
      tick(); tick(); tick(); tick();   // now in cycle 5
      chk("pre_reset_wb_count", LW'(wb_count), 3);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("midrst_ready", LW'(req_ready), 1);
      chk("midrst_outs", LW'({resp_valid, write_to_mem, fill_count, wb_count}), 0);
      chk("midrst_addrs", LW'({data_requested, where_to_write, resp_line_addr}), 0);
      chk("midrst_data", resp_data | data_to_write, 0);
      n = 0;
      for (int c = 0; c < 8; c++) begin
         if (resp_valid) n++;
         tick();
      end
      chk("midrst_no_resp", LW'(n), 0);

      // New clean request on both latencies: L=3 responds in cycle 4, L=1 in 2.
      r0 = -1; r1 = -1;
      req_valid = 1'b1; req_line_addr = 1;
      for (int c = 0; c < 8; c++) begin
         if (resp_valid && r0 < 0) r0 = c;
         if (resp_valid1 && r1 < 0) r1 = c;
         tick();
         idle_inputs();
      end
      chk("post_rst_resp_cycle", LW'(r0), 4);
      chk("post_rst_resp_data", resp_data, C_LINE);
      chk("post_rst_fill_count", LW'(fill_count), 1);
      chk("lat1_clean_cycle", LW'(r1), 2);
      chk("lat1_clean_data", resp_data1, C_LINE);

      // Dirty miss at latency 1: write in cycle 1 only, response in cycle 3.
      r1 = -1; wr1_n = 0;
      req_valid = 1'b1; req_line_addr = 3; req_wb = 1'b1;
      req_wb_addr = 'h30; req_wb_data = A5;
      for (int c = 0; c < 10; c++) begin
         if (resp_valid1 && r1 < 0) r1 = c;
         if (write_to_mem1) wr1_n += (c == 1) ? 1 : 100;
         tick();
         idle_inputs();
      end
      chk("lat1_dirty_cycle", LW'(r1), 3);
      chk("lat1_dirty_wr_pulse", LW'(wr1_n), 1);
      chk("lat1_dirty_counts", LW'({fill_count1, wb_count1}), LW'({16'd2, 16'd1}));
      chk("lat1_dirty_data", resp_data1, M3);

      $display("%0d/%0d checks passed", pass_n, total_n);
      $finish;
   end

   // Hard stop so a wedged run still reports.
   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit, expected completion");
      $display("%0d/%0d checks passed", pass_n, total_n + 1);
      $fatal(1, "timeout");
   end

endmodule
